// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_CH requesters, with bursts of up to MAX_BURST words.
// Define FIFO_WRITE_ARBITER_STATS_EN to build the saturating per-channel transfer counters on o_stat_cnt.
module fifo_write_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CH_WIDTH   = 2,
  parameter int MAX_BURST  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_CH-1:0]              i_req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   i_req_data,
  output logic [NUM_CH-1:0]              o_req_ready,
  input  logic                           i_fifo_full,
  output logic                           o_fifo_we,
  output logic [CH_WIDTH+DATA_WIDTH-1:0] o_fifo_wdata,
  output logic [NUM_CH-1:0]              o_grant,
  output logic                           o_busy,
  output logic [NUM_CH*16-1:0]           o_stat_cnt
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BC_W  = $clog2(MAX_BURST) + 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t              state_q, state_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]     burst_cnt_q, burst_cnt_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_CH];
  logic [IDX_W-1:0]      next_idx, start_idx, win_idx;
  logic [IDX_W:0]        scan_idx;
  logic                  win_found, xfer, last_beat, release_g;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign data_arr[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign next_idx  = (gidx_q == IDX_W'(NUM_CH - 1)) ? '0 : gidx_q + IDX_W'(1);
  assign start_idx = (state_q == ST_GRANT) ? next_idx : rr_ptr_q;

  // First valid channel scanning upward from start_idx, wrapping at NUM_CH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      scan_idx = {1'b0, start_idx} + (IDX_W+1)'(i);
      if (scan_idx >= (IDX_W+1)'(NUM_CH)) scan_idx = scan_idx - (IDX_W+1)'(NUM_CH);
      if (!win_found && i_req_valid[scan_idx[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IDX_W-1:0];
      end
    end
  end

  assign xfer      = (state_q == ST_GRANT) && i_req_valid[gidx_q] && !i_fifo_full;
  assign last_beat = (burst_cnt_q == BC_W'(MAX_BURST - 1));
  assign release_g = (state_q == ST_GRANT) && ((xfer && last_beat) || !i_req_valid[gidx_q]);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d     = ST_GRANT;
          gidx_d      = win_idx;
          grant_d     = NUM_CH'(1) << win_idx;
          burst_cnt_d = '0;
        end
      end
      default: begin
        if (release_g) begin
          // Re-arbitrate in the release cycle so back-to-back bursts have no bubble.
          rr_ptr_d    = next_idx;
          burst_cnt_d = '0;
          if (win_found) begin
            gidx_d  = win_idx;
            grant_d = NUM_CH'(1) << win_idx;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + BC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_busy       = (state_q == ST_GRANT);
  assign o_req_ready  = grant_q & {NUM_CH{~i_fifo_full}};
  assign o_fifo_we    = xfer;
  assign o_fifo_wdata = xfer ? {CH_WIDTH'(gidx_q), data_arr[gidx_q]} : '0;

`ifdef FIFO_WRITE_ARBITER_STATS_EN
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_stat
      logic [15:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (xfer && (gidx_q == IDX_W'(gi)) && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
      end
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
      end
      assign o_stat_cnt[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`else
  assign o_stat_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: a cycle-level reference model queues expected outputs,
// a negedge monitor pops and compares. Directed scenarios followed by randomized traffic.
module tb_fifo_write_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int CW  = 2;
  localparam int MB  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_ready;
  logic              fifo_full;
  logic              fifo_we;
  logic [CW+DW-1:0]  fifo_wdata;
  logic [NCH-1:0]    grant;
  logic              busy;
  logic [NCH*16-1:0] stat_cnt;

  fifo_write_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .CH_WIDTH(CW), .MAX_BURST(MB)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .i_fifo_full  (fifo_full),
    .o_fifo_we    (fifo_we),
    .o_fifo_wdata (fifo_wdata),
    .o_grant      (grant),
    .o_busy       (busy),
    .o_stat_cnt   (stat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       cyc;
    logic [NCH-1:0]    grant;
    logic [NCH-1:0]    ready;
    logic              we;
    logic [CW+DW-1:0]  wdata;
    logic              busy;
    logic [NCH*16-1:0] stat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  // Reference model: owner channel (-1 when idle), round-robin start, words taken in the current burst.
  int owner;
  int rr;
  int taken;
  int stat_m[NCH];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want, input int c);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, c, got, want);
    end
  endtask

  function automatic int pick(input logic [NCH-1:0] v, input int start);
    for (int i = 0; i < NCH; i++) begin
      if (v[(start + i) % NCH]) return (start + i) % NCH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    owner = -1;
    rr    = 0;
    taken = 0;
    for (int k = 0; k < NCH; k++) stat_m[k] = 0;
  endtask

  task automatic cycle(input logic [NCH-1:0] v, input logic f, input logic rn);
    logic [NCH*DW-1:0] d;
    exp_t e;
    bit wr;
    @(posedge clk);
    #1;
    d = NCH*DW'($urandom);
    req_valid = v;
    req_data  = d;
    fifo_full = f;
    rst_n     = rn;

    wr      = (owner >= 0) && v[owner] && !f;
    e.cyc   = cyc;
    e.grant = (owner >= 0) ? NCH'(1 << owner) : '0;
    e.ready = (owner >= 0 && !f) ? e.grant : '0;
    e.we    = wr;
    e.wdata = wr ? {CW'(owner), d[owner*DW +: DW]} : '0;
    e.busy  = (owner >= 0);
    e.stat  = '0;
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    for (int k = 0; k < NCH; k++) e.stat[k*16 +: 16] = 16'(stat_m[k]);
`endif
    exp_q.push_back(e);
    cyc++;

    if (!rn) begin
      model_reset();
    end else if (owner < 0) begin
      owner = pick(v, rr);
      taken = 0;
    end else begin
      if (wr) begin
        taken++;
        if (stat_m[owner] < 65535) stat_m[owner]++;
      end
      if (!v[owner] || (wr && taken == MB)) begin
        rr    = (owner + 1) % NCH;
        owner = pick(v, rr);
        taken = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("grant", 64'(grant), 64'(mon_e.grant), mon_e.cyc);
      chk("ready", 64'(req_ready), 64'(mon_e.ready), mon_e.cyc);
      chk("busy", 64'(busy), 64'(mon_e.busy), mon_e.cyc);
      chk("we", 64'(fifo_we), 64'(mon_e.we), mon_e.cyc);
      chk("stat", 64'(stat_cnt), 64'(mon_e.stat), mon_e.cyc);
      if (mon_e.we) begin
        chk("wdata", 64'(fifo_wdata), 64'(mon_e.wdata), mon_e.cyc);
        $display("write cyc=%0d ch=%0d data=%h", mon_e.cyc, fifo_wdata[CW+DW-1:DW], fifo_wdata[DW-1:0]);
      end
    end
  end

  initial begin
    logic [NCH-1:0] rv;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state, then single requester ch1 with back-to-back re-grant.
    cycle('0, 1'b0, 1'b0);
    cycle('0, 1'b0, 1'b1);
    repeat (14) cycle(4'b0010, 1'b0, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);

    // All channels: rotating bursts of MAX_BURST with no gaps.
    cycle('0, 1'b0, 1'b0);
    repeat (22) cycle(4'b1111, 1'b0, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);

    // Backpressure on ch2 after two writes.
    cycle('0, 1'b0, 1'b0);
    repeat (3) cycle(4'b0100, 1'b0, 1'b1);
    repeat (5) cycle(4'b0100, 1'b1, 1'b1);
    repeat (4) cycle(4'b0100, 1'b0, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);

    // Early release of ch0 with ch3 waiting.
    cycle('0, 1'b0, 1'b0);
    repeat (2) cycle(4'b1001, 1'b0, 1'b1);
    repeat (4) cycle(4'b1000, 1'b0, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);

    // Reset during the third write of ch1, then ch0 and ch1 contend.
    cycle('0, 1'b0, 1'b0);
    repeat (3) cycle(4'b0010, 1'b0, 1'b1);
    cycle(4'b0011, 1'b0, 1'b0);
    repeat (4) cycle(4'b0011, 1'b0, 1'b1);
    repeat (2) cycle(4'b0000, 1'b0, 1'b1);

    // Randomized traffic with sticky valids, random full and rare resets.
    rv = '0;
    for (int n = 0; n < 700; n++) begin
      for (int k = 0; k < NCH; k++) if ($urandom_range(7) == 0) rv[k] = ~rv[k];
      cycle(rv, ($urandom_range(4) == 0), !($urandom_range(99) == 0));
    end

    // Counter scenario: 10 writes from ch3 then 6 from ch0.
    cycle('0, 1'b0, 1'b0);
    repeat (11) cycle(4'b1000, 1'b0, 1'b1);
    repeat (7) cycle(4'b0001, 1'b0, 1'b1);
    repeat (3) cycle(4'b0000, 1'b0, 1'b1);

    @(negedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0, cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
